pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Sequences and supervises the 50 MHz→250 MHz encoder PLL from the free-running 50 MHz reference clock. The block holds the PLL in reset, waits for lock with a timeout and bounded retries, and qualifies lock stability before releasing the downstream system reset. It detects loss of lock in service, re-runs the bring-up sequence and reports status. It sits between the board reference clock/reset and the PLL's RESET/LOCK pins. The reset it drives into the 250 MHz domain is synchronised there by that domain.

## Interface
Parameters:
- RESET_CYCLES, 16: clk cycles pll_rst is held high per attempt (≥2)
- LOCK_TIMEOUT, 50000: clk cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz)
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release
- MAX_RETRIES, 4: failed attempts tolerated before FAIL (≥1)

Ports:
- clk  in  1  50 MHz free-running reference clock (same net as PLL clkin)
- rst_n  in  1  asynchronous active-low reset
- pll_lock  in  1  PLL lock output, asynchronous to clk
- restart  in  1  one-cycle request to re-run bring-up from any state
- pll_rst  out  1  PLL RESET pin, active-high
- sys_rst_n  out  1  active-low reset for logic clocked by the PLL output
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- lost_lock  out  1  one-cycle pulse on lock loss while in RUN
- retry_cnt  out  3  failed attempts in the current bring-up
- loss_cnt  out  8  saturating count of in-service lock losses
- state  out  3  RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4

## Operation
- pll_lock passes through a 2-flop synchroniser (lock_s). Only lock_s is used.
- One shared down-counter serves all timed states. It is loaded on every state entry.
- **RESET_PLL**: pll_rst=1. After RESET_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK**: pll_rst=0.
  - lock_s=1: go to STABLE.
  - LOCK_TIMEOUT cycles elapse without lock: retry_cnt+1.
    - New value < MAX_RETRIES: go to RESET_PLL.
    - Otherwise: go to FAIL.
- **STABLE**: pll_rst=0.
  - lock_s=0 at any cycle: return to WAIT_LOCK. The timeout restarts; retry_cnt is unchanged.
  - STABLE_CYCLES consecutive lock_s=1 cycles: go to RUN.
- **RUN**: sys_rst_n=1, ready=1.
  - lock_s=0: pulse lost_lock, increment loss_cnt (saturates at 255), clear retry_cnt, go to RESET_PLL.
- **FAIL**: pll_rst=1, fail=1, sys_rst_n=0. Held until restart or rst_n.
- **restart** (any state): go to RESET_PLL and clear retry_cnt. loss_cnt is kept.
- Priority, highest first: rst_n, restart, lock-loss/lock-drop, timer expiry.
  - A lock drop on the same cycle STABLE completes returns to WAIT_LOCK.
  - A lock arriving on the timeout cycle goes to STABLE; no retry is counted.
- Arithmetic:
  - Counter width is clog2 of the largest parameter.
  - retry_cnt never exceeds MAX_RETRIES.
  - loss_cnt holds at 8'hFF.

## Timing
- During rst_n=0 and immediately after release: state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, fail=0, lost_lock=0, retry_cnt=0, loss_cnt=0, synchroniser=0.
- All outputs are registered and take their new value on the same edge the state changes.
- After rst_n rises, pll_rst stays high for exactly RESET_CYCLES clk edges.
- pll_lock rising (held) to sys_rst_n rising: STABLE_CYCLES+3 edges (2 sync + 1 entry + STABLE_CYCLES).
- pll_lock falling in RUN to sys_rst_n=0, pll_rst=1 and lost_lock=1: 3 edges. lost_lock is exactly 1 cycle wide.
- restart sampled high: state=RESET_PLL and pll_rst=1 on the next edge.
- Attempt length without lock: RESET_CYCLES+LOCK_TIMEOUT cycles.
- rst_n assertion mid-sequence forces reset values asynchronously. No partial counts survive.

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean bring-up: release rst_n, raise pll_lock 10 cycles later and hold it.
  - pll_rst high for 4 cycles.
  - sys_rst_n and ready rise 11 edges after pll_lock.
  - retry_cnt=0.
- No lock: hold pll_lock=0.
  - Two attempts of 24 cycles each.
  - retry_cnt=1 after the first, then fail=1, state=4, pll_rst=1.
  - Assert restart: state=0, retry_cnt=0.
- Glitchy lock: pulse pll_lock high for 5 cycles during STABLE, then hold high.
  - Returns to WAIT_LOCK; no retry counted.
  - RUN reached 11 edges after the final rise.
- In-service loss: in RUN, drop pll_lock for 3 cycles.
  - 3 edges later: lost_lock pulses once, loss_cnt=1, sys_rst_n=0, pll_rst=1.
  - After re-lock, RUN is re-entered.
- Saturation and priority:
  - Force 260 losses: loss_cnt=255.
  - Assert restart on the same cycle as a lock drop in RUN: restart wins, lost_lock stays 0.
- Async reset mid-STABLE: pull rst_n low for 1 cycle; all outputs return to reset values immediately.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if
// Groups the PLL-facing and status signals of pll_lock_supervisor.
//   pll_lock   PLL lock output (asynchronous to clk)
//   restart    one-cycle request to re-run bring-up
//   pll_rst    PLL RESET pin, active-high
//   sys_rst_n  active-low reset for the PLL output domain
//   ready      high only in RUN
//   fail       high only in FAIL
//   lost_lock  one-cycle pulse on in-service lock loss
//   retry_cnt  failed attempts in the current bring-up
//   loss_cnt   saturating count of in-service lock losses
//   state      RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4
// master: environment side (drives pll_lock/restart); slave: the supervisor.
interface pll_lock_supervisor_if;
   logic       pll_lock;
   logic       restart;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic       fail;
   logic       lost_lock;
   logic [2:0] retry_cnt;
   logic [7:0] loss_cnt;
   logic [2:0] state;

   modport master (
      output pll_lock, restart,
      input  pll_rst, sys_rst_n, ready, fail, lost_lock, retry_cnt, loss_cnt, state
   );

   modport slave (
      input  pll_lock, restart,
      output pll_rst, sys_rst_n, ready, fail, lost_lock, retry_cnt, loss_cnt, state
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Brings up the encoder PLL from the 50 MHz reference: holds it in reset, waits for lock with a
// timeout and bounded retries, qualifies lock stability, then releases the downstream reset.
// Lock loss while running re-runs the sequence and is counted.
// Ports:
//   clk    50 MHz free-running reference clock
//   rst_n  asynchronous active-low reset
//   bus    pll_lock_supervisor_if.slave (pll_lock/restart in; PLL reset and status out)
module pll_lock_supervisor #(
   parameter int unsigned RESET_CYCLES  = 16,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   pll_lock_supervisor_if.slave bus
);

   localparam int unsigned Max01 = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned Max23 = (STABLE_CYCLES > MAX_RETRIES) ? STABLE_CYCLES : MAX_RETRIES;
   localparam int unsigned MaxParam = (Max01 > Max23) ? Max01 : Max23;
   localparam int unsigned CntW = (MaxParam > 1) ? $clog2(MaxParam) : 1;

   // The counter is loaded with N-1 and a state leaves when it reads zero, giving N cycles.
   localparam logic [CntW-1:0] ResetLoad  = CntW'(RESET_CYCLES - 1);
   localparam logic [CntW-1:0] WaitLoad   = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [CntW-1:0] StableLoad = CntW'(STABLE_CYCLES - 1);

   typedef enum logic [2:0] {
      StResetPll = 3'd0,
      StWaitLock = 3'd1,
      StStable   = 3'd2,
      StRun      = 3'd3,
      StFail     = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      retry_q, retry_d;
   logic [7:0]      loss_q, loss_d;
   logic            lost_q, lost_d;
   logic            pll_rst_q, pll_rst_d;
   logic            run_q, run_d;
   logic            fail_q, fail_d;
   logic            lock_meta_q, lock_s;
   logic [3:0]      retry_inc;

   // Two-flop synchroniser; pll_lock has no relation to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_s      <= 1'b0;
      end else begin
         lock_meta_q <= bus.pll_lock;
         lock_s      <= lock_meta_q;
      end
   end

   assign retry_inc = {1'b0, retry_q} + 4'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      lost_d  = 1'b0;

      if (bus.restart) begin
         state_d = StResetPll;
         cnt_d   = ResetLoad;
         retry_d = '0;
      end else begin
         unique case (state_q)
            StResetPll: begin
               if (cnt_q == '0) begin
                  state_d = StWaitLock;
                  cnt_d   = WaitLoad;
               end
            end
            StWaitLock: begin
               // Lock wins over a simultaneous timeout.
               if (lock_s) begin
                  state_d = StStable;
                  cnt_d   = StableLoad;
               end else if (cnt_q == '0) begin
                  retry_d = retry_inc[2:0];
                  if (32'(retry_inc) < MAX_RETRIES) begin
                     state_d = StResetPll;
                     cnt_d   = ResetLoad;
                  end else begin
                     state_d = StFail;
                     cnt_d   = '0;
                  end
               end
            end
            StStable: begin
               // A drop on the completing cycle still returns to WAIT_LOCK.
               if (!lock_s) begin
                  state_d = StWaitLock;
                  cnt_d   = WaitLoad;
               end else if (cnt_q == '0) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end
            end
            StRun: begin
               if (!lock_s) begin
                  state_d = StResetPll;
                  cnt_d   = ResetLoad;
                  retry_d = '0;
                  lost_d  = 1'b1;
                  loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
               end
            end
            StFail: ;
            default: begin
               state_d = StResetPll;
               cnt_d   = ResetLoad;
            end
         endcase
      end

      // Outputs follow the next state so they change on the same edge as the state.
      pll_rst_d = (state_d == StResetPll) || (state_d == StFail);
      run_d     = (state_d == StRun);
      fail_d    = (state_d == StFail);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StResetPll;
         cnt_q     <= ResetLoad;
         retry_q   <= '0;
         loss_q    <= '0;
         lost_q    <= 1'b0;
         pll_rst_q <= 1'b1;
         run_q     <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         loss_q    <= loss_d;
         lost_q    <= lost_d;
         pll_rst_q <= pll_rst_d;
         run_q     <= run_d;
         fail_q    <= fail_d;
      end
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.sys_rst_n = run_q;
   assign bus.ready     = run_q;
   assign bus.fail      = fail_q;
   assign bus.lost_lock = lost_q;
   assign bus.retry_cnt = retry_q;
   assign bus.loss_cnt  = loss_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;
   localparam int unsigned RESET_CYCLES  = 4;
   localparam int unsigned LOCK_TIMEOUT  = 20;
   localparam int unsigned STABLE_CYCLES = 8;
   localparam int unsigned MAX_RETRIES   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   pll_lock_supervisor_if bus ();

   pll_lock_supervisor #(
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // {state, pll_rst, sys_rst_n, ready, fail, lost_lock, retry_cnt, loss_cnt}
   logic [18:0] obs;
   assign obs = {bus.state, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fail, bus.lost_lock,
                 bus.retry_cnt, bus.loss_cnt};
   localparam logic [18:0] RstVals = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};

   // Advance n active edges, then settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bring_up();
      int k;
      rst_n = 1'b0;
      bus.pll_lock = 1'b0;
      bus.restart = 1'b0;
      step(1);
      rst_n = 1'b1;
      bus.pll_lock = 1'b1;
      k = 0;
      while (bus.ready !== 1'b1 && k < 40) begin
         step(1);
         k++;
      end
      vectors++;
      if (bus.ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bring_up_ready: got %b expected 1", bus.ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.pll_lock = 1'b0;
      bus.restart = 1'b0;
      step(2);
      vectors++;
      if (obs !== RstVals) begin
         miscompares++;
         $display("FAIL reset_hold: got %h expected %h", obs, RstVals);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (obs !== RstVals) begin
         miscompares++;
         $display("FAIL reset_release: got %h expected %h", obs, RstVals);
      end
   endtask

   // Continues straight from test_reset's release.
   task automatic test_clean_bring_up();
      step(3);
      vectors++;
      if ({bus.state, bus.pll_rst} !== {3'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL clean_rst_edge3: got %h expected %h", {bus.state, bus.pll_rst}, 4'h1);
      end
      step(1);
      vectors++;
      if ({bus.state, bus.pll_rst} !== {3'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL clean_rst_edge4: got %h expected %h", {bus.state, bus.pll_rst}, 4'h2);
      end
      step(6);
      bus.pll_lock = 1'b1;
      step(10);
      vectors++;
      if ({bus.state, bus.sys_rst_n, bus.ready} !== {3'd2, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL clean_edge10: got %h expected %h", {bus.state, bus.sys_rst_n, bus.ready},
                  5'h08);
      end
      step(1);
      vectors++;
      if ({bus.state, bus.sys_rst_n, bus.ready, bus.retry_cnt} !== {3'd3, 1'b1, 1'b1, 3'd0})
      begin
         miscompares++;
         $display("FAIL clean_edge11: got %h expected %h",
                  {bus.state, bus.sys_rst_n, bus.ready, bus.retry_cnt}, 8'h78);
      end
   endtask

   task automatic test_no_lock();
      rst_n = 1'b0;
      bus.pll_lock = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(23);
      vectors++;
      if ({bus.state, bus.retry_cnt} !== {3'd1, 3'd0}) begin
         miscompares++;
         $display("FAIL nolock_edge23: got %h expected %h", {bus.state, bus.retry_cnt}, 6'o10);
      end
      step(1);
      vectors++;
      if ({bus.state, bus.retry_cnt, bus.pll_rst} !== {3'd0, 3'd1, 1'b1}) begin
         miscompares++;
         $display("FAIL nolock_retry1: got %h expected %h",
                  {bus.state, bus.retry_cnt, bus.pll_rst}, 7'h03);
      end
      step(23);
      vectors++;
      if ({bus.state, bus.retry_cnt} !== {3'd1, 3'd1}) begin
         miscompares++;
         $display("FAIL nolock_edge47: got %h expected %h", {bus.state, bus.retry_cnt}, 6'o11);
      end
      step(1);
      vectors++;
      if (obs !== {3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0}) begin
         miscompares++;
         $display("FAIL nolock_fail: got %h expected %h", obs,
                  {3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0});
      end
      step(5);
      vectors++;
      if ({bus.state, bus.fail} !== {3'd4, 1'b1}) begin
         miscompares++;
         $display("FAIL nolock_fail_held: got %h expected %h", {bus.state, bus.fail}, 4'h9);
      end
      bus.restart = 1'b1;
      step(1);
      bus.restart = 1'b0;
      vectors++;
      if ({bus.state, bus.retry_cnt, bus.fail, bus.pll_rst} !== {3'd0, 3'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL nolock_restart: got %h expected %h",
                  {bus.state, bus.retry_cnt, bus.fail, bus.pll_rst}, 8'h01);
      end
   endtask

   task automatic test_glitch();
      rst_n = 1'b0;
      bus.pll_lock = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(4);
      bus.pll_lock = 1'b1;
      step(3);
      vectors++;
      if (bus.state !== 3'd2) begin
         miscompares++;
         $display("FAIL glitch_stable: got %0d expected 2", bus.state);
      end
      step(2);
      bus.pll_lock = 1'b0;
      step(2);
      vectors++;
      if (bus.state !== 3'd2) begin
         miscompares++;
         $display("FAIL glitch_still_stable: got %0d expected 2", bus.state);
      end
      step(1);
      vectors++;
      if ({bus.state, bus.retry_cnt} !== {3'd1, 3'd0}) begin
         miscompares++;
         $display("FAIL glitch_back_wait: got %h expected %h", {bus.state, bus.retry_cnt}, 6'o10);
      end
      step(1);
      bus.pll_lock = 1'b1;
      step(10);
      vectors++;
      if ({bus.state, bus.sys_rst_n} !== {3'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL glitch_edge10: got %h expected %h", {bus.state, bus.sys_rst_n}, 4'h4);
      end
      step(1);
      vectors++;
      if ({bus.state, bus.sys_rst_n, bus.ready, bus.retry_cnt} !== {3'd3, 1'b1, 1'b1, 3'd0})
      begin
         miscompares++;
         $display("FAIL glitch_run: got %h expected %h",
                  {bus.state, bus.sys_rst_n, bus.ready, bus.retry_cnt}, 8'h78);
      end
   endtask

   task automatic test_loss();
      bring_up();
      bus.pll_lock = 1'b0;
      step(2);
      vectors++;
      if ({bus.state, bus.ready, bus.lost_lock} !== {3'd3, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL loss_edge2: got %h expected %h", {bus.state, bus.ready, bus.lost_lock},
                  5'h0E);
      end
      step(1);
      vectors++;
      if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd1}) begin
         miscompares++;
         $display("FAIL loss_edge3: got %h expected %h", obs,
                  {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd1});
      end
      bus.pll_lock = 1'b1;
      step(1);
      vectors++;
      if ({bus.lost_lock, bus.loss_cnt} !== {1'b0, 8'd1}) begin
         miscompares++;
         $display("FAIL loss_pulse_width: got %h expected %h", {bus.lost_lock, bus.loss_cnt},
                  9'h001);
      end
      step(11);
      vectors++;
      if (bus.state !== 3'd2) begin
         miscompares++;
         $display("FAIL loss_relock_stable: got %0d expected 2", bus.state);
      end
      step(1);
      vectors++;
      if ({bus.state, bus.ready} !== {3'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL loss_relock_run: got %h expected %h", {bus.state, bus.ready}, 4'h7);
      end
   endtask

   task automatic test_saturation();
      int k;
      int timeouts;
      timeouts = 0;
      bring_up();
      for (int i = 0; i < 260; i++) begin
         bus.pll_lock = 1'b0;
         k = 0;
         while (bus.lost_lock !== 1'b1 && k < 10) begin
            step(1);
            k++;
         end
         if (bus.lost_lock !== 1'b1) timeouts++;
         if (i == 253) begin
            vectors++;
            if (bus.loss_cnt !== 8'd254) begin
               miscompares++;
               $display("FAIL sat_254: got %0d expected 254", bus.loss_cnt);
            end
         end
         if (i == 254) begin
            vectors++;
            if (bus.loss_cnt !== 8'd255) begin
               miscompares++;
               $display("FAIL sat_255: got %0d expected 255", bus.loss_cnt);
            end
         end
         bus.pll_lock = 1'b1;
         k = 0;
         while (bus.ready !== 1'b1 && k < 40) begin
            step(1);
            k++;
         end
         if (bus.ready !== 1'b1) timeouts++;
      end
      vectors++;
      if (timeouts != 0) begin
         miscompares++;
         $display("FAIL sat_handshake: got %0d timeouts expected 0", timeouts);
      end
      vectors++;
      if (bus.loss_cnt !== 8'd255) begin
         miscompares++;
         $display("FAIL sat_260: got %0d expected 255", bus.loss_cnt);
      end
   endtask

   // Restart lands on the same edge the lock drop reaches RUN.
   task automatic test_priority();
      bus.pll_lock = 1'b0;
      step(2);
      bus.restart = 1'b1;
      step(1);
      bus.restart = 1'b0;
      vectors++;
      if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd255}) begin
         miscompares++;
         $display("FAIL prio_restart: got %h expected %h", obs,
                  {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd255});
      end
      bus.pll_lock = 1'b1;
      step(1);
      vectors++;
      if (bus.lost_lock !== 1'b0) begin
         miscompares++;
         $display("FAIL prio_no_lost: got %b expected 0", bus.lost_lock);
      end
   endtask

   task automatic test_async_reset();
      int k;
      k = 0;
      while (bus.state !== 3'd2 && k < 30) begin
         step(1);
         k++;
      end
      vectors++;
      if (bus.state !== 3'd2) begin
         miscompares++;
         $display("FAIL async_reach_stable: got %0d expected 2", bus.state);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (obs !== RstVals) begin
         miscompares++;
         $display("FAIL async_immediate: got %h expected %h", obs, RstVals);
      end
      step(1);
      rst_n = 1'b1;
      step(3);
      vectors++;
      if ({bus.state, bus.pll_rst} !== {3'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL async_rst_edge3: got %h expected %h", {bus.state, bus.pll_rst}, 4'h1);
      end
      step(1);
      vectors++;
      if ({bus.state, bus.pll_rst} !== {3'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL async_rst_edge4: got %h expected %h", {bus.state, bus.pll_rst}, 4'h2);
      end
      step(8);
      vectors++;
      if (bus.state !== 3'd2) begin
         miscompares++;
         $display("FAIL async_edge12: got %0d expected 2", bus.state);
      end
      step(1);
      vectors++;
      if ({bus.state, bus.ready} !== {3'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL async_run: got %h expected %h", {bus.state, bus.ready}, 4'h7);
      end
   endtask

   initial begin
      bus.pll_lock = 1'b0;
      bus.restart = 1'b0;
      test_reset();
      test_clean_bring_up();
      test_no_lock();
      test_glitch();
      test_loss();
      test_saturation();
      test_priority();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
